// File: rtl/if_inst_queue.sv
// if_inst_queue
//   Instruction fetch queue between the instruction-memory response path and
//   the decode stage. Holds {pc, inst, adel} entries in program order in a
//   circular buffer. Decode sees the head entry, and its op_code/rt/funct
//   fields, combinationally. A branch flush can keep one entry as the delay
//   slot. If that entry has not been fetched yet, the flush captures the
//   incoming fetch response in its place.
//
//   Optional build macro: IFQ_BYPASS_EN
//     Defined   - when the queue is empty, an incoming entry is forwarded
//                 straight to out_*. If decode takes it that cycle, it is
//                 never stored.
//     Undefined - no forwarding. An entry reaches out_* one cycle after it
//                 is pushed.
//
// Ports
//   clk, resetn            system clock (rising edge); asynchronous
//                          active-low reset
//   in_valid/in_ready      fetch-side handshake
//   in_pc/in_inst/in_adel  fetched entry
//   out_valid/out_ready    decode-side handshake
//   out_pc/out_inst/out_adel
//                          head entry (all zero when the queue is empty)
//   op_code, rt, funct     head instruction fields
//   flush, flush_keep      discard the queue, optionally keeping a delay slot
//   count                  current occupancy, 0..DEPTH

module if_inst_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst,
  input  logic             in_adel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  output logic             out_adel,
  output logic [5:0]       op_code,
  output logic [4:0]       rt,
  output logic [5:0]       funct,
  input  logic             flush,
  input  logic             flush_keep,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0]   LP_FULL  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] LP_PONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   LP_CONE  = (PTR_W+1)'(1);

  logic [31:0]      r_pc_mem   [DEPTH];
  logic [31:0]      r_inst_mem [DEPTH];
  logic             r_adel_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic             w_empty;
  logic             w_in_ready;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;
  logic             w_keep_hit;
  logic             w_late_push;
  logic             w_wr;
  logic [PTR_W-1:0] w_head_nxt;
  logic [PTR_W-1:0] w_tail_nxt;
  logic [PTR_W:0]   w_count_nxt;

  assign w_empty    = (r_count == '0);
  assign w_in_ready = (r_count != LP_FULL);

`ifdef IFQ_BYPASS_EN
  assign w_bypass = w_empty && in_valid && !flush;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed entry that decode takes in the same cycle is never stored.
  assign w_push = in_valid && w_in_ready && !flush && !(w_bypass && out_ready);
  assign w_pop  = !w_empty && out_ready && !flush;

  // Delay-slot candidate: head+1 if decode is taking the head this cycle,
  // otherwise head. It exists only if the queue holds more entries than
  // that offset.
  assign w_keep_hit  = (r_count > {{PTR_W{1'b0}}, out_ready});
  assign w_late_push = flush && flush_keep && !w_keep_hit && in_valid;
  assign w_wr        = w_push || w_late_push;

  always_comb begin
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    if (flush) begin
      if (flush_keep && w_keep_hit) begin
        w_head_nxt  = r_head + {{(PTR_W-1){1'b0}}, out_ready};
        w_tail_nxt  = w_head_nxt + LP_PONE;
        w_count_nxt = LP_CONE;
      end else begin
        w_head_nxt  = r_tail;
        w_tail_nxt  = r_tail;
        w_count_nxt = '0;
        if (w_late_push) begin
          w_tail_nxt  = r_tail + LP_PONE;
          w_count_nxt = LP_CONE;
        end
      end
    end else begin
      if (w_push) w_tail_nxt = r_tail + LP_PONE;
      if (w_pop)  w_head_nxt = r_head + LP_PONE;
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + LP_CONE;
        2'b01:   w_count_nxt = r_count - LP_CONE;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Storage has no reset; unoccupied slots are masked off by count.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_pc_mem[r_tail]   <= in_pc;
      r_inst_mem[r_tail] <= in_inst;
      r_adel_mem[r_tail] <= in_adel;
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_pc    = 32'h0;
    out_inst  = 32'h0;
    out_adel  = 1'b0;
    if (w_bypass) begin
      out_valid = 1'b1;
      out_pc    = in_pc;
      out_inst  = in_inst;
      out_adel  = in_adel;
    end else if (!w_empty) begin
      out_valid = 1'b1;
      out_pc    = r_pc_mem[r_head];
      out_inst  = r_inst_mem[r_head];
      out_adel  = r_adel_mem[r_head];
    end
  end

  assign op_code  = out_inst[31:26];
  assign rt       = out_inst[20:16];
  assign funct    = out_inst[5:0];
  assign in_ready = w_in_ready;
  assign count    = r_count;

endmodule

// File: tb/tb_if_inst_queue.sv
module tb_if_inst_queue;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic            clk;
  logic            resetn;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_pc;
  logic [31:0]     in_inst;
  logic            in_adel;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_pc;
  logic [31:0]     out_inst;
  logic            out_adel;
  logic [5:0]      op_code;
  logic [4:0]      rt;
  logic [5:0]      funct;
  logic            flush;
  logic            flush_keep;
  logic [PTR_W:0]  count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } ent_t;

  ent_t mq[$];
  int   checks = 0;
  int   errors = 0;

  if_inst_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_adel(in_adel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_adel(out_adel),
    .op_code(op_code), .rt(rt), .funct(funct),
    .flush(flush), .flush_keep(flush_keep), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of entries updated by the handshake rules.
  function automatic void model_update();
    ent_t e;
    int   idx;
    bit   take_bypass;
    bit   do_push;
    e.pc = in_pc; e.inst = in_inst; e.adel = in_adel;
    take_bypass = 1'b0;
    if (flush) begin
      if (!flush_keep) mq.delete();
      else begin
        idx = out_ready ? 1 : 0;
        if (mq.size() > idx) begin
          e = mq[idx];
          mq.delete();
          mq.push_back(e);
        end else begin
          mq.delete();
          if (in_valid) mq.push_back(e);
        end
      end
    end else begin
`ifdef IFQ_BYPASS_EN
      take_bypass = (mq.size() == 0) && in_valid && out_ready;
`endif
      do_push = in_valid && (mq.size() < DEPTH) && !take_bypass;
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
  endfunction

  task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                       input logic adel, input logic ordy, input logic fl, input logic fk);
    in_valid = iv; in_pc = pc; in_inst = inst; in_adel = adel;
    out_ready = ordy; flush = fl; flush_keep = fk;
  endtask

  // Advance one clock: the model sees the same inputs as the DUT at the edge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic clear_q();
    drive(0, 0, 0, 0, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    resetn = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== '0 || out_inst !== 32'h0) begin
      errors++;
      $display("FAIL reset: out_valid=%b in_ready=%b count=%0d out_inst=%h, want 0 1 0 0",
               out_valid, in_ready, count, out_inst);
    end
    @(negedge clk);
    resetn = 1'b1;
    mq.delete();
  endtask

  task automatic test_single_push();
    drive(1, 32'hBFC00000, 32'h24080001, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (out_valid !== 1'b1 || count !== 3'd1 || out_pc !== 32'hBFC00000) begin
      errors++;
      $display("FAIL single_push: out_valid=%b count=%0d out_pc=%h, want 1 1 bfc00000",
               out_valid, count, out_pc);
    end
    checks++;
    if (op_code !== 6'h09 || rt !== 5'd8 || funct !== 6'h01) begin
      errors++;
      $display("FAIL single_fields: op_code=%h rt=%0d funct=%h, want 09 8 01", op_code, rt, funct);
    end
    clear_q();
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 32'h1000 + 32'(4*i), 32'h1000 + 32'(i), 0, 0, 0, 0);
      step();
    end
    drive(1, 32'h1010, 32'h0, 0, 0, 0, 0);
    #1;
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full: count=%0d in_ready=%b, want 4 0", count, in_ready);
    end
    step();
    checks++;
    if (count !== 3'd4 || out_pc !== 32'h1000) begin
      errors++;
      $display("FAIL full_reject: count=%0d out_pc=%h, want 4 00001000", count, out_pc);
    end
    drive(0, 0, 0, 0, 1, 0, 0);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_same_cycle: in_ready=%b, want 0", in_ready);
    end
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (in_ready !== 1'b1 || count !== 3'd3 || out_pc !== 32'h1004) begin
      errors++;
      $display("FAIL full_pop: in_ready=%b count=%0d out_pc=%h, want 1 3 00001004",
               in_ready, count, out_pc);
    end
    clear_q();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h2000 + 32'(4*i), 32'hA000 + 32'(i), 0, 0, 0, 0);
      step();
    end
    for (int k = 0; k < 6; k++) begin
      drive(1, 32'h2000 + 32'(4*(k+2)), 32'hA000 + 32'(k+2), 0, 1, 0, 0);
      #1;
      checks++;
      if (out_pc !== 32'h2000 + 32'(4*k) || out_inst !== 32'hA000 + 32'(k)) begin
        errors++;
        $display("FAIL b2b_order k=%0d: out_pc=%h out_inst=%h, want %h %h", k, out_pc, out_inst,
                 32'h2000 + 32'(4*k), 32'hA000 + 32'(k));
      end
      step();
      checks++;
      if (count !== 3'd2) begin
        errors++;
        $display("FAIL b2b_count k=%0d: count=%0d, want 2", k, count);
      end
    end
    clear_q();
  endtask

  task automatic test_flush_keep();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h100 + 32'(4*i), 32'h0, 0, 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 1, 1, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (count !== 3'd1 || out_pc !== 32'h104) begin
      errors++;
      $display("FAIL flush_keep: count=%0d out_pc=%h, want 1 00000104", count, out_pc);
    end
    clear_q();
  endtask

  task automatic test_flush_late();
    drive(1, 32'h200, 32'h11, 0, 0, 1, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (count !== 3'd1 || out_pc !== 32'h200) begin
      errors++;
      $display("FAIL flush_late_keep: count=%0d out_pc=%h, want 1 00000200", count, out_pc);
    end
    clear_q();
    drive(1, 32'h200, 32'h11, 0, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_late_nokeep: count=%0d out_valid=%b, want 0 0", count, out_valid);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h300 + 32'(4*i), 32'hFFFF0000 + 32'(i), 0, 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL async_reset: out_valid=%b count=%0d, want 0 0", out_valid, count);
    end
    mq.delete();
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checks++;
    if (count !== 3'd0 || out_inst !== 32'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_reset: count=%0d out_inst=%h in_ready=%b, want 0 0 1",
               count, out_inst, in_ready);
    end
  endtask

  task automatic test_bypass();
`ifdef IFQ_BYPASS_EN
    drive(1, 32'h400, 32'h24090002, 1, 1, 0, 0);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h400 || out_adel !== 1'b1) begin
      errors++;
      $display("FAIL bypass_out: out_valid=%b out_pc=%h out_adel=%b, want 1 00000400 1",
               out_valid, out_pc, out_adel);
    end
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL bypass_count: count=%0d, want 0", count);
    end
`else
    drive(1, 32'h400, 32'h24090002, 1, 1, 0, 0);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_bypass: out_valid=%b, want 0", out_valid);
    end
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (count !== 3'd1 || out_pc !== 32'h400 || out_adel !== 1'b1) begin
      errors++;
      $display("FAIL no_bypass_store: count=%0d out_pc=%h out_adel=%b, want 1 00000400 1",
               count, out_pc, out_adel);
    end
`endif
    clear_q();
  endtask

  task automatic test_random();
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einst;
    logic        eadel;
    logic [31:0] pc_next;
    pc_next = 32'h8000_0000;
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 9) < 7), pc_next, $urandom, ($urandom_range(0, 7) == 0),
            $urandom_range(0, 1), ($urandom_range(0, 15) == 0), $urandom_range(0, 1));
      #1;
      ev = (mq.size() > 0); epc = 32'h0; einst = 32'h0; eadel = 1'b0;
      if (mq.size() > 0) begin
        epc = mq[0].pc; einst = mq[0].inst; eadel = mq[0].adel;
      end
`ifdef IFQ_BYPASS_EN
      if (mq.size() == 0 && in_valid && !flush) begin
        ev = 1'b1; epc = in_pc; einst = in_inst; eadel = in_adel;
      end
`endif
      checks++;
      if (out_valid !== ev || out_pc !== epc || out_inst !== einst || out_adel !== eadel) begin
        errors++;
        $display("FAIL rand_out n=%0d: valid=%b pc=%h inst=%h adel=%b, want %b %h %h %b",
                 n, out_valid, out_pc, out_inst, out_adel, ev, epc, einst, eadel);
      end
      checks++;
      if (count !== (PTR_W+1)'(mq.size()) || in_ready !== (mq.size() != DEPTH) ||
          op_code !== einst[31:26] || rt !== einst[20:16] || funct !== einst[5:0]) begin
        errors++;
        $display("FAIL rand_state n=%0d: count=%0d in_ready=%b op=%h rt=%h fn=%h, want count %0d",
                 n, count, in_ready, op_code, rt, funct, mq.size());
      end
      if (in_valid) pc_next = pc_next + 32'd4;
      step();
    end
    clear_q();
  endtask

  initial begin
    resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_single_push();
    test_full();
    test_back_to_back();
    test_flush_keep();
    test_flush_late();
    test_async_reset();
    test_bypass();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_inst_queue.md
Name: if_inst_queue

Overview:
- Instruction fetch queue between the instruction-memory response path and the decode stage.
- Buffers fetched {pc, inst, exception flag} entries in program order with valid/ready handshakes on both sides.
- Supplies the head instruction's op_code, rt and funct fields directly to the decode controller.
- Supports a branch flush that optionally preserves the delay-slot entry.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- in_valid  input  1  fetch response valid.
- in_ready  output  1  queue can accept an entry.
- in_pc  input  32  PC of the fetched instruction.
- in_inst  input  32  fetched instruction word.
- in_adel  input  1  fetch address-error flag for this entry.
- out_valid  output  1  head entry valid toward decode.
- out_ready  input  1  decode accepts the head this cycle.
- out_pc  output  32  head PC.
- out_inst  output  32  head instruction.
- out_adel  output  1  head address-error flag.
- op_code  output  6  out_inst[31:26].
- rt  output  5  out_inst[20:16].
- funct  output  6  out_inst[5:0].
- flush  input  1  discard queued entries (branch taken or exception).
- flush_keep  input  1  with flush: keep one entry as the delay slot.
- count  output  PTR_W+1  current occupancy.

Behaviour:
- Reset:
  - The clk/resetn pair is exactly as decided: one clock `clk`; reset `resetn` is asynchronous and active-low.
  - Reset clears head, tail and count to 0, so out_valid=0 and in_ready=1.
  - Storage contents need not reset.
  - Reset asserted mid-operation discards all entries immediately.
- Storage: circular buffer indexed by head/tail pointers of PTR_W bits.
  - Pointers wrap naturally from DEPTH-1 to 0.
  - count tracks occupancy in the range 0..DEPTH.
- in_ready = (count != DEPTH). It is purely registered-state based; there is no combinational dependence on out_ready.
- push = in_valid && in_ready && !flush. A push writes the tail entry and increments tail.
- pop = out_valid && out_ready && !flush. A pop increments head.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- Empty queue: out_valid=0.
  - out_pc=0, out_inst=32'h0 (NOP), out_adel=0.
  - op_code, rt and funct are therefore all 0.
- Non-empty queue: outputs show the head entry combinationally from storage.
  - Latency from push to visibility at out_* is 1 cycle (non-bypass build).
- Full queue (count==DEPTH): in_ready=0. A pop in that cycle frees one slot, which becomes visible the next cycle.
- flush=1, flush_keep=0: next state is head=tail, count=0. That cycle's push and pop are both ignored.
- flush=1, flush_keep=1:
  - Consider the entry at head+1 if out_ready=1, otherwise the entry at head.
  - If that entry exists, it becomes the sole entry (count=1) and all others are dropped.
  - If no such entry exists, count=0, and the incoming in_* (if in_valid) is pushed as the sole entry. This captures a delay slot arriving late.
- flush_keep without flush is ignored.
- Entries marked in_adel are queued normally; decode handles the exception.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- Defined: when count==0 and in_valid=1 and flush=0, the in_* values are forwarded combinationally to out_* with out_valid=1.
  - If out_ready=1 the entry is consumed that cycle and not stored (zero latency).
  - Otherwise it is stored normally.
  - in_ready still depends only on count.
- Undefined: no bypass path; minimum push-to-out latency is 1 cycle.

Test Plan:
1. Reset then push pc=0xBFC00000 inst=0x24080001 with out_ready=0 -> next cycle out_valid=1, count=1, op_code=0x09, rt=8, funct=0x01.
2. Push 4 entries with out_ready=0 -> count=4, in_ready=0; a 5th in_valid is not accepted; pop once -> in_ready=1 next cycle, head pc advances by 4.
3. count=2, in_valid=1 and out_ready=1 together for 6 cycles -> count stays 2; outputs keep program order across pointer wrap.
4. count=3 (pcs 0x100, 0x104, 0x108), flush=1, flush_keep=1, out_ready=1 -> next cycle count=1, out_pc=0x104.
5. count=0, flush=1, flush_keep=1, in_valid=1 with pc=0x200 -> next cycle count=1, out_pc=0x200. The same case with flush_keep=0 -> count=0.
6. Assert resetn=0 mid-stream with count=3 -> out_valid falls without waiting for a clock edge; after release count=0 and out_inst=0. With IFQ_BYPASS_EN defined: empty queue, in_valid=1, out_ready=1 -> out_valid=1 in the same cycle and count stays 0.
